// File: rtl/comp_conv_arb.sv
`default_nettype none
// ============================================================================
// Module   : comp_conv_arb
// Purpose  : Two-requester round-robin arbiter that shares one sign-magnitude
//            to two's-complement converter and one registered output port.
// Revision : 1.0
// ============================================================================
module comp_conv_arb #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [DW-1:0]    req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DW-1:0]    req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [DW-1:0]    r_data;
    logic             r_id;
    logic             r_last_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant;
    logic [DW-1:0]    w_sel;
    logic [DW-2:0]    w_mag;
    logic [DW-1:0]    w_conv;
    logic             w_xfer;

    // A tie goes to whichever requester was not the most recent winner.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_id);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_id);

    // Readies are forced low during reset so no handshake lands in a reset cycle.
    assign w_can_accept = ~rst & ((r_state == EMPTY) | out_ready);
    assign req0_ready   = w_can_accept & w_grant0;
    assign req1_ready   = w_can_accept & w_grant1;
    assign w_grant      = req0_ready | req1_ready;

    assign w_sel  = w_grant1 ? req1_data : req0_data;
    assign w_mag  = (~w_sel[DW-2:0]) + {{(DW-2){1'b0}}, 1'b1};
    assign w_conv = w_sel[DW-1] ? {1'b1, w_mag} : w_sel;

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign conv_cnt  = r_cnt;
    assign w_xfer    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_id      <= 1'b0;
            r_last_id <= 1'b1;
            r_cnt     <= '0;
        end else begin
            if (w_xfer) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_grant) begin
                r_state   <= FULL;
                r_data    <= w_conv;
                r_id      <= w_grant1;
                r_last_id <= w_grant1;
            end else if (w_xfer) begin
                r_state <= EMPTY;
            end
        end
    end

endmodule
`default_nettype wire
